// File: rtl/conv32b_8b_if.sv
// Handshake bundle for the 32b->8b transmit converter: word-side valid/ready in,
// byte-side valid/last out. The converter uses the slave modport, its driver the master.
interface conv32b_8b_if;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_in;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        last_out;

  modport master (
    output data_in, valid_in,
    input  ready_in, data_out, valid_out, last_out
  );

  modport slave (
    input  data_in, valid_in,
    output ready_in, data_out, valid_out, last_out
  );
endinterface

// File: rtl/conv32b_8b.sv
// 32-bit word to 8-bit byte serializer with a DEPTH-entry word FIFO, one byte per clk_4f.
// Byte order is MSB first unless CONV32B_8B_LSB_FIRST_EN is defined (then LSB first).
module conv32b_8b #(
  parameter int DEPTH = 2
) (
  input  logic         clk_4f,
  input  logic         reset,
  conv32b_8b_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] word_q;
  logic [7:0]  data_out_q;
  logic        valid_out_q;
  logic        last_out_q;

  logic push, pop;

  // cnt is the index of the byte about to leave, in emission order.
  function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] n);
`ifdef CONV32B_8B_LSB_FIRST_EN
    return w[{n, 3'b000} +: 8];
`else
    return w[{~n, 3'b000} +: 8];
`endif
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign bus.ready_in = (count_q < CNT_W'(DEPTH));
  assign push = bus.valid_in && bus.ready_in;
  // A new word may start from IDLE or on the edge right after a last byte (gapless).
  assign pop  = ((state_q == IDLE) || last_out_q) && (count_q != '0);

  // NOTE: storage array has no reset; only pointers and count define validity.
  always_ff @(posedge clk_4f) begin
    if (push) mem[wr_ptr_q] <= bus.data_in;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
    end else if (pop) begin
      state_q     <= SHIFT;
      word_q      <= mem[rd_ptr_q];
      data_out_q  <= pick(mem[rd_ptr_q], 2'd0);
      cnt_q       <= 2'd1;
      valid_out_q <= 1'b1;
      last_out_q  <= 1'b0;
    end else if ((state_q == SHIFT) && !last_out_q) begin
      data_out_q  <= pick(word_q, cnt_q);
      last_out_q  <= (cnt_q == 2'd3);
      cnt_q       <= cnt_q + 2'd1;
      valid_out_q <= 1'b1;
    end else begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.last_out  = last_out_q;

endmodule

// File: tb/tb_conv32b_8b.sv
// Self-checking bench for conv32b_8b: directed scenarios plus a randomized stream,
// all compared against a queue-based word/byte reference model.
module tb_conv32b_8b;
  localparam int DEPTH = 2;

  logic clk_4f = 1'b0;
  logic reset  = 1'b1;
  conv32b_8b_if bus ();

  conv32b_8b #(.DEPTH(DEPTH)) dut (.clk_4f(clk_4f), .reset(reset), .bus(bus));

  always #5 clk_4f = ~clk_4f;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [31:0] fifo_m [$];
  logic [7:0]  bytes_m [$];
  logic [7:0]  exp_data  = 8'h00;
  logic        exp_valid = 1'b0;
  logic        exp_last  = 1'b0;
  logic        exp_ready = 1'b1;

  function automatic logic [7:0] nth_byte(input logic [31:0] w, input int k);
`ifdef CONV32B_8B_LSB_FIRST_EN
    return 8'(w >> (8 * k));
`else
    return 8'(w >> (8 * (3 - k)));
`endif
  endfunction

  task automatic model_clear();
    fifo_m.delete();
    bytes_m.delete();
    exp_data = 8'h00; exp_valid = 1'b0; exp_last = 1'b0; exp_ready = 1'b1;
  endtask

  // Advance one clock; the model sees the inputs as they stood before the edge.
  task automatic tick();
    logic        acc;
    logic [31:0] w;
    acc = bus.valid_in && (fifo_m.size() < DEPTH) && !reset;
    w   = bus.data_in;
    @(posedge clk_4f);
    cyc++;
    if (reset) begin
      model_clear();
    end else begin
      if (bytes_m.size() == 0 && fifo_m.size() > 0) begin
        logic [31:0] h;
        h = fifo_m.pop_front();
        for (int k = 0; k < 4; k++) bytes_m.push_back(nth_byte(h, k));
      end
      if (bytes_m.size() > 0) begin
        exp_data  = bytes_m.pop_front();
        exp_valid = 1'b1;
        exp_last  = (bytes_m.size() == 0);
      end else begin
        exp_data = 8'h00; exp_valid = 1'b0; exp_last = 1'b0;
      end
      if (acc) fifo_m.push_back(w);
      exp_ready = (fifo_m.size() < DEPTH);
    end
    #1;
  endtask

  task automatic test_reset();
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    reset = 1'b1;
    #3;
    n_checks++;
    if ({bus.valid_out, bus.last_out, bus.data_out, bus.ready_in} !== {1'b0, 1'b0, 8'h00, 1'b1})
      $display("FAIL reset_state got v=%b l=%b d=%h r=%b need v=0 l=0 d=00 r=1",
               bus.valid_out, bus.last_out, bus.data_out, bus.ready_in);
    else n_pass++;
    model_clear();
    @(negedge clk_4f);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({bus.valid_out, bus.last_out, bus.data_out, bus.ready_in} !== {1'b0, 1'b0, 8'h00, 1'b1})
        $display("FAIL reset_idle cyc=%0d got v=%b l=%b d=%h r=%b need v=0 l=0 d=00 r=1",
                 cyc, bus.valid_out, bus.last_out, bus.data_out, bus.ready_in);
      else n_pass++;
    end
  endtask

  // seq holds the expected emission order, first byte in seq[31:24].
  task automatic test_single_word(input logic [31:0] w, input logic [31:0] seq);
    bus.valid_in = 1'b1;
    bus.data_in  = w;
    tick();
    bus.valid_in = 1'b0;
    bus.data_in  = $urandom;
    n_checks++;
    if (bus.valid_out !== 1'b0)
      $display("FAIL single_latency w=%h got valid=%b need 0 on accept edge", w, bus.valid_out);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] eb;
      tick();
      eb = seq[8*(3-i) +: 8];
      n_checks++;
      if ({bus.valid_out, bus.last_out, bus.data_out} !== {1'b1, (i == 3), eb})
        $display("FAIL single_byte w=%h i=%0d got v=%b l=%b d=%h need v=1 l=%b d=%h",
                 w, i, bus.valid_out, bus.last_out, bus.data_out, (i == 3), eb);
      else n_pass++;
    end
    tick();
    n_checks++;
    if ({bus.valid_out, bus.last_out, bus.data_out} !== {1'b0, 1'b0, 8'h00})
      $display("FAIL single_tail w=%h got v=%b l=%b d=%h need idle", w,
               bus.valid_out, bus.last_out, bus.data_out);
    else n_pass++;
  endtask

  task automatic stream_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      n_checks++;
      if ({bus.valid_out, bus.last_out, bus.data_out, bus.ready_in} !==
          {exp_valid, exp_last, exp_data, exp_ready})
        $display("FAIL %s cyc=%0d got v=%b l=%b d=%h r=%b need v=%b l=%b d=%h r=%b", tag, cyc,
                 bus.valid_out, bus.last_out, bus.data_out, bus.ready_in,
                 exp_valid, exp_last, exp_data, exp_ready);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    int          idx;
    int          saw_full;
    words[0] = 32'hDDDDDDDD; words[1] = 32'h00000003; words[2] = $urandom;
    idx = 0;
    saw_full = 0;
    bus.valid_in = 1'b1;
    bus.data_in  = words[0];
    for (int i = 0; i < 20 && idx < 3; i++) begin
      if (bus.ready_in) idx++;
      stream_check("b2b", 1);
      if (!bus.ready_in) saw_full++;
      if (idx < 3) bus.data_in = words[idx];
    end
    bus.valid_in = 1'b0;
    n_checks++;
    if (saw_full == 0) $display("FAIL b2b_full got ready_low_cycles=0 need >0");
    else n_pass++;
    stream_check("b2b_drain", 14);
  endtask

  task automatic test_valid_low();
    bus.valid_in = 1'b0;
    bus.data_in  = 32'hAAAAAAAA;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({bus.valid_out, bus.ready_in} !== 2'b01)
        $display("FAIL valid_low cyc=%0d got v=%b r=%b need v=0 r=1", cyc,
                 bus.valid_out, bus.ready_in);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_word();
    bus.valid_in = 1'b1;
    bus.data_in  = 32'h11223344;
    tick();
    bus.data_in  = $urandom;
    tick();
    bus.valid_in = 1'b0;
    stream_check("mid_pre", 1);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.valid_out, bus.last_out, bus.data_out, bus.ready_in} !== {1'b0, 1'b0, 8'h00, 1'b1})
      $display("FAIL mid_reset got v=%b l=%b d=%h r=%b need v=0 l=0 d=00 r=1",
               bus.valid_out, bus.last_out, bus.data_out, bus.ready_in);
    else n_pass++;
    model_clear();
    tick();
    @(negedge clk_4f);
    reset = 1'b0;
    stream_check("mid_after", 6);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.valid_in = ($urandom_range(0, 3) != 0);
      bus.data_in  = $urandom;
      stream_check("random", 1);
    end
    bus.valid_in = 1'b0;
    stream_check("random_drain", 12);
  endtask

  initial begin
    test_reset();
    test_single_word(32'hFFFFFFFF, 32'hFFFFFFFF);
`ifdef CONV32B_8B_LSB_FIRST_EN
    test_single_word(32'h00000003, 32'h03000000);
`else
    test_single_word(32'h00000003, 32'h00000003);
`endif
    test_back_to_back();
    test_valid_low();
    test_reset_mid_word();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
